mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Moore-style control FSM that sequences a multicycle MIPS datapath: IR, PC, RegFile, ALU and the unified memory share one clock, and each instruction takes 3–5 cycles.
- Decodes opcode/funct from the instruction register and drives every mux select and write enable. This replaces the hand-driven control that the testbench supplies today.
- Provides a run/idle handshake so a bench or debug unit can start, stop or single-step the core.

Parameters:
- TRAP_ON_ILLEGAL, 0, 1 = an unknown opcode parks the FSM in S_HALT until reset; 0 = the instruction is skipped and the FSM returns to S_FETCH/S_IDLE.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- run  input  1  1 = allow the next instruction fetch; sampled only in S_IDLE and in the last state of each instruction
- opcode  input  6  instr[31:26] from the IR
- funct  input  6  instr[5:0] from the IR
- zero  input  1  ALU zero flag
- pc_en  output  1  PC write enable = pc_write | (branch & zero)
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write_en  output  1  memory write
- ir_write  output  1  IR load
- reg_write_en  output  1  register-file write
- reg_dst  output  1  0 = rt, 1 = rd
- mem_to_reg  output  1  0 = ALUOut, 1 = memory data register
- alu_src_a  output  1  0 = PC, 1 = rs register
- alu_src_b  output  2  00 = rt reg, 01 = const 4, 10 = sign_imm, 11 = sign_imm<<2
- alu_ctrl  output  3  ALU operation
- pc_src  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- instr_done  output  1  one-cycle pulse in the final state of each instruction
- illegal_op  output  1  sticky; set on an unknown opcode
- busy  output  1  1 in every state except S_IDLE and S_HALT
- state_dbg  output  4  current state encoding

Behaviour:
Reset and output rules:
- rst_n low forces state to S_IDLE and clears illegal_op, asynchronously.
- In S_IDLE all outputs are 0.
- All outputs except pc_en are decoded purely from the registered state, plus funct in S_EXEC. pc_en also depends combinationally on zero.
- Any output not listed for a state is 0.

State encodings and actions:
- S_IDLE (0): wait. Goes to S_FETCH when run = 1.
- S_FETCH (1): iord = 0, ir_write = 1, alu_src_a = 0, alu_src_b = 01, alu_ctrl = ADD, pc_src = 00, pc_write = 1. Always goes to S_DECODE.
- S_DECODE (2): alu_src_a = 0, alu_src_b = 11, alu_ctrl = ADD (precomputes the branch target). Next state by opcode:
  - lw/sw → S_MEMADR
  - R-type → S_EXEC
  - beq → S_BRANCH
  - addi → S_ADDIEX
  - j → S_JUMP
  - other → illegal handling
- S_MEMADR (3): alu_src_a = 1, alu_src_b = 10, ADD. lw → S_MEMRD; sw → S_MEMWR.
- S_MEMRD (4): iord = 1. Goes to S_MEMWB.
- S_MEMWB (5): reg_write_en = 1, reg_dst = 0, mem_to_reg = 1. Final state.
- S_MEMWR (6): iord = 1, mem_write_en = 1. Final state.
- S_EXEC (7): alu_src_a = 1, alu_src_b = 00, alu_ctrl from funct. Goes to S_ALUWB.
- S_ALUWB (8): reg_write_en = 1, reg_dst = 1, mem_to_reg = 0. Final state.
- S_BRANCH (9): alu_src_a = 1, alu_src_b = 00, SUB, branch = 1, pc_src = 01. Final state.
- S_ADDIEX (10): alu_src_a = 1, alu_src_b = 10, ADD. Goes to S_ADDIWB.
- S_ADDIWB (11): reg_write_en = 1, reg_dst = 0. Final state.
- S_JUMP (12): pc_src = 10, pc_write = 1. Final state.
- S_HALT (13): all outputs 0, busy = 0. Exits only on reset.

Final-state rules:
- instr_done = 1 in every final state.
- Next state is S_FETCH if run = 1, else S_IDLE.
- Dropping run mid-instruction never aborts it; the current instruction always completes.

Latency in cycles, counted from S_FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.

Encodings:
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- Funct → alu_ctrl: add 100000 → 010; sub 100010 → 110; and 100100 → 000; or 100101 → 001; slt 101010 → 111.
- Unknown funct: alu_ctrl = 010 and illegal_op is set; the writeback still occurs.

Illegal opcode handling in S_DECODE:
- illegal_op is set on the next edge.
- TRAP_ON_ILLEGAL = 1: go to S_HALT.
- TRAP_ON_ILLEGAL = 0: pulse instr_done and go to S_FETCH/S_IDLE per run, i.e. 2-cycle skip. The PC has already advanced by 4.

Optional Feature:
- Macro MC_CTRL_BNE_EN.
- Defined: opcode 000101 (bne) is decoded to S_BRANCH with a registered is_bne flag, and pc_en = pc_write | (branch & (zero ^ is_bne)).
- Undefined: 000101 is an illegal opcode.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode/funct localparams
  - ALU_ADD/SUB/AND/OR/SLT codes, shared with alu
  - state encodings
  - alu_src_b and pc_src select constants
- One sub-module, alu_decoder: combinational funct + alu_op[1:0] → alu_ctrl, plus a bad_funct flag. The FSM emits alu_op as 00 = add, 01 = sub, 10 = funct.

Test Plan:
- Reset with run = 0 → state_dbg = 0, all outputs 0, busy = 0. Raise run → S_FETCH with ir_write = 1, pc_en = 1, alu_src_b = 01.
- lw (0x8C080004), run held high → states 1, 2, 3, 4, 5. reg_write_en = 1 and mem_to_reg = 1 only in cycle 5; instr_done pulses once; cycle 6 is S_FETCH.
- R-type sub (funct 100010) → alu_ctrl = 110 in S_EXEC; S_ALUWB has reg_dst = 1. slt (funct 101010) → alu_ctrl = 111.
- beq in S_BRANCH: zero = 1 → pc_en = 1, pc_src = 01; zero = 0 → pc_en = 0. Both cases reach S_FETCH on cycle 4.
- Opcode 111111: with TRAP_ON_ILLEGAL = 0 → illegal_op = 1, instr_done pulses in S_DECODE, then S_FETCH. With TRAP_ON_ILLEGAL = 1 → S_HALT (13) held for 10 cycles, busy = 0.
- Drop run during S_MEMADR of sw → S_MEMWR still asserts mem_write_en = 1, then S_IDLE. Assert rst_n low in S_EXEC → asynchronous jump to S_IDLE, reg_write_en is never asserted.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control path: opcodes, funct codes,
// ALU operation codes, mux select values and FSM state encodings.
package mips_ctrl_pkg;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Funct codes (instr[5:0]) for R-type
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation codes, shared with the ALU
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // FSM -> ALU decoder request
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // alu_src_b selects
  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // pc_src selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12,
    S_HALT   = 4'd13
  } state_e;

endpackage

// File: rtl/mc_controller_if.sv
// Control bus between mc_controller and the multicycle datapath.
// master = controller side, slave = datapath / bench side.
interface mc_controller_if;
  logic       run;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       pc_en;
  logic       iord;
  logic       mem_write_en;
  logic       ir_write;
  logic       reg_write_en;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_ctrl;
  logic [1:0] pc_src;
  logic       instr_done;
  logic       illegal_op;
  logic       busy;
  logic [3:0] state_dbg;

  modport master (
    input  run, opcode, funct, zero,
    output pc_en, iord, mem_write_en, ir_write, reg_write_en, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, alu_ctrl, pc_src, instr_done, illegal_op, busy, state_dbg
  );

  modport slave (
    output run, opcode, funct, zero,
    input  pc_en, iord, mem_write_en, ir_write, reg_write_en, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, alu_ctrl, pc_src, instr_done, illegal_op, busy, state_dbg
  );
endinterface

// File: rtl/alu_decoder.sv
// Combinational ALU control decoder: FSM alu_op request plus funct -> alu_ctrl.
// bad_funct flags an unknown funct when the FSM asks for a funct decode.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] i_funct,
  input  logic [1:0] i_alu_op,
  output logic [2:0] o_alu_ctrl,
  output logic       o_bad_funct
);

  // Decode requested ALU operation; unknown funct falls back to ADD
  always_comb begin
    o_alu_ctrl  = ALU_ADD;
    o_bad_funct = 1'b0;
    unique case (i_alu_op)
      ALUOP_ADD: o_alu_ctrl = ALU_ADD;
      ALUOP_SUB: o_alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          FN_ADD:  o_alu_ctrl = ALU_ADD;
          FN_SUB:  o_alu_ctrl = ALU_SUB;
          FN_AND:  o_alu_ctrl = ALU_AND;
          FN_OR:   o_alu_ctrl = ALU_OR;
          FN_SLT:  o_alu_ctrl = ALU_SLT;
          default: o_bad_funct = 1'b1;
        endcase
      end
      default: o_alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Moore control FSM for a multicycle MIPS datapath with run/idle handshake.
// Optional macro MC_CTRL_BNE_EN adds bne decoding through S_BRANCH.
module mc_controller
  import mips_ctrl_pkg::*;
#(
  parameter bit TRAP_ON_ILLEGAL = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  mc_controller_if.master bus
);

  state_e     r_state, w_state_next;
  logic       r_illegal_op;
  logic       w_op_legal, w_is_bne;
  logic       w_pc_write, w_branch, w_iord, w_mem_write_en, w_ir_write;
  logic       w_reg_write_en, w_reg_dst, w_mem_to_reg, w_alu_src_a;
  logic       w_alu_used, w_instr_done, w_bad_funct;
  logic [1:0] w_alu_src_b, w_pc_src, w_alu_op;
  logic [2:0] w_dec_ctrl;
  state_e     w_after_done;

  alu_decoder u_alu_decoder (
    .i_funct     (bus.funct),
    .i_alu_op    (w_alu_op),
    .o_alu_ctrl  (w_dec_ctrl),
    .o_bad_funct (w_bad_funct)
  );

  // Opcode legality check used in S_DECODE
  always_comb begin
    w_op_legal = 1'b0;
    case (bus.opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: w_op_legal = 1'b1;
`ifdef MC_CTRL_BNE_EN
      OP_BNE: w_op_legal = 1'b1;
`endif
      default: w_op_legal = 1'b0;
    endcase
  end

`ifdef MC_CTRL_BNE_EN
  logic r_is_bne;

  // Latch branch polarity in S_DECODE; opcode is stable for the instruction anyway
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_bne <= 1'b0;
    end else if (r_state == S_DECODE) begin
      r_is_bne <= (bus.opcode == OP_BNE);
    end
  end

  assign w_is_bne = r_is_bne;
`else
  assign w_is_bne = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Sticky illegal flag: unknown opcode in decode or unknown funct in execute
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal_op <= 1'b0;
    end else if ((r_state == S_DECODE && !w_op_legal) || (r_state == S_EXEC && w_bad_funct)) begin
      r_illegal_op <= 1'b1;
    end
  end

  assign w_after_done = bus.run ? S_FETCH : S_IDLE;

  // Next-state and per-state control decode
  always_comb begin
    w_state_next   = r_state;
    w_pc_write     = 1'b0;
    w_branch       = 1'b0;
    w_iord         = 1'b0;
    w_mem_write_en = 1'b0;
    w_ir_write     = 1'b0;
    w_reg_write_en = 1'b0;
    w_reg_dst      = 1'b0;
    w_mem_to_reg   = 1'b0;
    w_alu_src_a    = 1'b0;
    w_alu_src_b    = SRCB_RT;
    w_alu_op       = ALUOP_ADD;
    w_alu_used     = 1'b0;
    w_pc_src       = PCSRC_ALU;
    w_instr_done   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.run) w_state_next = S_FETCH;
      end
      S_FETCH: begin
        w_ir_write   = 1'b1;
        w_alu_src_b  = SRCB_FOUR;
        w_alu_used   = 1'b1;
        w_pc_write   = 1'b1;
        w_state_next = S_DECODE;
      end
      S_DECODE: begin
        // Precompute branch target into ALUOut
        w_alu_src_b = SRCB_IMM_SH;
        w_alu_used  = 1'b1;
        case (bus.opcode)
          OP_LW, OP_SW: w_state_next = S_MEMADR;
          OP_RTYPE:     w_state_next = S_EXEC;
          OP_BEQ:       w_state_next = S_BRANCH;
`ifdef MC_CTRL_BNE_EN
          OP_BNE:       w_state_next = S_BRANCH;
`endif
          OP_ADDI:      w_state_next = S_ADDIEX;
          OP_J:         w_state_next = S_JUMP;
          default: begin
            if (TRAP_ON_ILLEGAL) begin
              w_state_next = S_HALT;
            end else begin
              // Skip: PC already advanced in fetch
              w_instr_done = 1'b1;
              w_state_next = w_after_done;
            end
          end
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = SRCB_IMM;
        w_alu_used   = 1'b1;
        w_state_next = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_iord       = 1'b1;
        w_state_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_reg_write_en = 1'b1;
        w_mem_to_reg   = 1'b1;
        w_instr_done   = 1'b1;
        w_state_next   = w_after_done;
      end
      S_MEMWR: begin
        w_iord         = 1'b1;
        w_mem_write_en = 1'b1;
        w_instr_done   = 1'b1;
        w_state_next   = w_after_done;
      end
      S_EXEC: begin
        w_alu_src_a  = 1'b1;
        w_alu_op     = ALUOP_FUNCT;
        w_alu_used   = 1'b1;
        w_state_next = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write_en = 1'b1;
        w_reg_dst      = 1'b1;
        w_instr_done   = 1'b1;
        w_state_next   = w_after_done;
      end
      S_BRANCH: begin
        w_alu_src_a  = 1'b1;
        w_alu_op     = ALUOP_SUB;
        w_alu_used   = 1'b1;
        w_branch     = 1'b1;
        w_pc_src     = PCSRC_ALUOUT;
        w_instr_done = 1'b1;
        w_state_next = w_after_done;
      end
      S_ADDIEX: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = SRCB_IMM;
        w_alu_used   = 1'b1;
        w_state_next = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_reg_write_en = 1'b1;
        w_instr_done   = 1'b1;
        w_state_next   = w_after_done;
      end
      S_JUMP: begin
        w_pc_src     = PCSRC_JUMP;
        w_pc_write   = 1'b1;
        w_instr_done = 1'b1;
        w_state_next = w_after_done;
      end
      S_HALT: w_state_next = S_HALT;
      default: w_state_next = S_IDLE;
    endcase
  end

  assign bus.pc_en        = w_pc_write | (w_branch & (bus.zero ^ w_is_bne));
  assign bus.iord         = w_iord;
  assign bus.mem_write_en = w_mem_write_en;
  assign bus.ir_write     = w_ir_write;
  assign bus.reg_write_en = w_reg_write_en;
  assign bus.reg_dst      = w_reg_dst;
  assign bus.mem_to_reg   = w_mem_to_reg;
  assign bus.alu_src_a    = w_alu_src_a;
  assign bus.alu_src_b    = w_alu_src_b;
  // ALU code is only meaningful (and only driven) in states that use the ALU
  assign bus.alu_ctrl     = w_alu_used ? w_dec_ctrl : 3'b000;
  assign bus.pc_src       = w_pc_src;
  assign bus.instr_done   = w_instr_done;
  assign bus.illegal_op   = r_illegal_op;
  assign bus.busy         = (r_state != S_IDLE) && (r_state != S_HALT);
  assign bus.state_dbg    = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// Directed, table-driven bench for mc_controller. u_dut0 skips illegal opcodes,
// u_dut1 traps them.
module tb_mc_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mc_controller_if if0 ();
  mc_controller_if if1 ();

  mc_controller #(.TRAP_ON_ILLEGAL(1'b0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  mc_controller #(.TRAP_ON_ILLEGAL(1'b1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  // Output bundle: pe io mw iw rw rd mr sa sb[2] ac[3] ps[2] dn il by
  logic [17:0] act0, act1;
  assign act0 = {if0.pc_en, if0.iord, if0.mem_write_en, if0.ir_write, if0.reg_write_en,
                 if0.reg_dst, if0.mem_to_reg, if0.alu_src_a, if0.alu_src_b, if0.alu_ctrl,
                 if0.pc_src, if0.instr_done, if0.illegal_op, if0.busy};
  assign act1 = {if1.pc_en, if1.iord, if1.mem_write_en, if1.ir_write, if1.reg_write_en,
                 if1.reg_dst, if1.mem_to_reg, if1.alu_src_a, if1.alu_src_b, if1.alu_ctrl,
                 if1.pc_src, if1.instr_done, if1.illegal_op, if1.busy};

  localparam logic [17:0] O_IDLE      = 18'b0;
  localparam logic [17:0] O_FETCH     = 18'b1_0_0_1_0_0_0_0_01_010_00_0_0_1;
  localparam logic [17:0] O_DECODE    = 18'b0_0_0_0_0_0_0_0_11_010_00_0_0_1;
  localparam logic [17:0] O_DEC_SKIP  = 18'b0_0_0_0_0_0_0_0_11_010_00_1_0_1;
  localparam logic [17:0] O_MEMADR    = 18'b0_0_0_0_0_0_0_1_10_010_00_0_0_1;
  localparam logic [17:0] O_MEMRD     = 18'b0_1_0_0_0_0_0_0_00_000_00_0_0_1;
  localparam logic [17:0] O_MEMWB     = 18'b0_0_0_0_1_0_1_0_00_000_00_1_0_1;
  localparam logic [17:0] O_MEMWR     = 18'b0_1_1_0_0_0_0_0_00_000_00_1_0_1;
  localparam logic [17:0] O_EXEC_SUB  = 18'b0_0_0_0_0_0_0_1_00_110_00_0_0_1;
  localparam logic [17:0] O_EXEC_SLT  = 18'b0_0_0_0_0_0_0_1_00_111_00_0_0_1;
  localparam logic [17:0] O_EXEC_ADD  = 18'b0_0_0_0_0_0_0_1_00_010_00_0_0_1;
  localparam logic [17:0] O_ALUWB     = 18'b0_0_0_0_1_1_0_0_00_000_00_1_0_1;
  localparam logic [17:0] O_BR_TAKEN  = 18'b1_0_0_0_0_0_0_1_00_110_01_1_0_1;
  localparam logic [17:0] O_BR_NOT    = 18'b0_0_0_0_0_0_0_1_00_110_01_1_0_1;
  localparam logic [17:0] O_ADDIEX    = 18'b0_0_0_0_0_0_0_1_10_010_00_0_0_1;
  localparam logic [17:0] O_ADDIWB    = 18'b0_0_0_0_1_0_0_0_00_000_00_1_0_1;
  localparam logic [17:0] O_JUMP      = 18'b1_0_0_0_0_0_0_0_00_000_10_1_0_1;
  localparam logic [17:0] O_HALT      = 18'b0_0_0_0_0_0_0_0_00_000_00_0_1_0;
  localparam logic [17:0] IL          = 18'b10;

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000, J = 6'b000010, BAD = 6'b111111;
  localparam logic [5:0] F_SUB = 6'b100010, F_SLT = 6'b101010, F_NONE = 6'b000000;

  typedef struct {
    logic        run;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        zero;
    logic [3:0]  st;
    logic [17:0] out;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic run, input logic [5:0] op, input logic [5:0] fn,
                     input logic zero, input logic [3:0] st, input logic [17:0] out);
    vec_t v;
    v.run = run; v.op = op; v.fn = fn; v.zero = zero; v.st = st; v.out = out;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [3:0] ast, input logic [3:0] est,
                       input logic [17:0] aout, input logic [17:0] eout);
    checks++;
    if (ast !== est) begin
      errors++;
      $display("FAIL %s state got %0d want %0d", nm, ast, est);
    end
    checks++;
    if (aout !== eout) begin
      errors++;
      $display("FAIL %s outputs got %b want %b", nm, aout, eout);
    end
  endtask

  task automatic drive0(input logic run, input logic [5:0] op, input logic [5:0] fn,
                        input logic zero);
    if0.run = run; if0.opcode = op; if0.funct = fn; if0.zero = zero;
  endtask

  task automatic drive1(input logic run, input logic [5:0] op, input logic [5:0] fn);
    if1.run = run; if1.opcode = op; if1.funct = fn; if1.zero = 1'b0;
  endtask

  initial begin
    drive0(1'b0, R, F_NONE, 1'b0);
    drive1(1'b0, R, F_NONE);

    // Main table (u_dut0): one record per cycle
    add(0, LW, 0, 0, 0, O_IDLE);
    add(1, LW, 0, 0, 0, O_IDLE);
    add(1, LW, 0, 0, 1, O_FETCH);                 // lw 0x8C080004
    add(1, LW, 0, 0, 2, O_DECODE);
    add(1, LW, 0, 0, 3, O_MEMADR);
    add(1, LW, 0, 0, 4, O_MEMRD);
    add(1, LW, 0, 0, 5, O_MEMWB);
    add(1, R, F_SUB, 0, 1, O_FETCH);              // sub
    add(1, R, F_SUB, 0, 2, O_DECODE);
    add(1, R, F_SUB, 0, 7, O_EXEC_SUB);
    add(1, R, F_SUB, 0, 8, O_ALUWB);
    add(1, R, F_SLT, 0, 1, O_FETCH);              // slt
    add(1, R, F_SLT, 0, 2, O_DECODE);
    add(1, R, F_SLT, 0, 7, O_EXEC_SLT);
    add(1, R, F_SLT, 0, 8, O_ALUWB);
    add(1, BEQ, 0, 1, 1, O_FETCH);                // beq taken
    add(1, BEQ, 0, 1, 2, O_DECODE);
    add(1, BEQ, 0, 1, 9, O_BR_TAKEN);
    add(1, BEQ, 0, 0, 1, O_FETCH);                // beq not taken
    add(1, BEQ, 0, 0, 2, O_DECODE);
    add(1, BEQ, 0, 0, 9, O_BR_NOT);
    add(1, ADDI, 0, 0, 1, O_FETCH);               // addi
    add(1, ADDI, 0, 0, 2, O_DECODE);
    add(1, ADDI, 0, 0, 10, O_ADDIEX);
    add(1, ADDI, 0, 0, 11, O_ADDIWB);
    add(1, J, 0, 0, 1, O_FETCH);                  // j
    add(1, J, 0, 0, 2, O_DECODE);
    add(1, J, 0, 0, 12, O_JUMP);
    add(1, SW, 0, 0, 1, O_FETCH);                 // sw, run dropped in memadr
    add(1, SW, 0, 0, 2, O_DECODE);
    add(0, SW, 0, 0, 3, O_MEMADR);
    add(0, SW, 0, 0, 6, O_MEMWR);
    add(0, SW, 0, 0, 0, O_IDLE);
    add(1, BAD, 0, 0, 0, O_IDLE);                 // illegal opcode, skip mode
    add(1, BAD, 0, 0, 1, O_FETCH);
    add(1, BAD, 0, 0, 2, O_DEC_SKIP);
    add(1, J, 0, 0, 1, O_FETCH | IL);
    add(1, J, 0, 0, 2, O_DECODE | IL);
    add(0, J, 0, 0, 12, O_JUMP | IL);

    repeat (2) @(negedge clk);
    #1;
    check("reset_dut1", if1.state_dbg, 4'd0, act1, O_IDLE);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive0(vecs[i].run, vecs[i].op, vecs[i].fn, vecs[i].zero);
      #1;
      check($sformatf("vec%0d", i), if0.state_dbg, vecs[i].st, act0, vecs[i].out);
    end

    // Asynchronous reset while in S_EXEC: writeback must never happen
    @(negedge clk);
    drive0(1'b1, R, F_SUB, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    check("rst_pre_exec", if0.state_dbg, 4'd7, act0, O_EXEC_SUB | IL);
    rst_n = 1'b0;
    #1;
    check("rst_async", if0.state_dbg, 4'd0, act0, O_IDLE);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 1) begin
        rst_n = 1'b1;
        if0.run = 1'b0;
      end
      #1;
      checks++;
      if (if0.reg_write_en !== 1'b0) begin
        errors++;
        $display("FAIL rst_no_wb%0d reg_write_en got %b want 0", k, if0.reg_write_en);
      end
    end

    // Trap mode (u_dut1): illegal opcode parks in S_HALT
    @(negedge clk);
    drive1(1'b1, BAD, F_NONE);
    #1;
    check("trap_idle", if1.state_dbg, 4'd0, act1, O_IDLE);
    @(negedge clk); #1;
    check("trap_fetch", if1.state_dbg, 4'd1, act1, O_FETCH);
    @(negedge clk); #1;
    check("trap_decode", if1.state_dbg, 4'd2, act1, O_DECODE);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      check($sformatf("trap_halt%0d", k), if1.state_dbg, 4'd13, act1, O_HALT);
    end

    // Unknown funct: ADD fallback, illegal flagged, writeback still occurs
    @(negedge clk);
    rst_n = 1'b0;
    drive1(1'b0, R, F_NONE);
    #1;
    check("halt_reset", if1.state_dbg, 4'd0, act1, O_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    if1.run = 1'b1;
    #1;
    check("bf_idle", if1.state_dbg, 4'd0, act1, O_IDLE);
    @(negedge clk); #1;
    check("bf_fetch", if1.state_dbg, 4'd1, act1, O_FETCH);
    @(negedge clk); #1;
    check("bf_decode", if1.state_dbg, 4'd2, act1, O_DECODE);
    @(negedge clk); #1;
    check("bf_exec", if1.state_dbg, 4'd7, act1, O_EXEC_ADD);
    @(negedge clk);
    if1.run = 1'b0;
    #1;
    check("bf_aluwb", if1.state_dbg, 4'd8, act1, O_ALUWB | IL);
    @(negedge clk); #1;
    check("bf_idle_end", if1.state_dbg, 4'd0, act1, O_IDLE | IL);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
